adder_selftest: RTL and testbench
=================================

Name: adder_selftest

Overview:
- On-chip exhaustive self-test sequencer for a WIDTH-bit ripple-carry adder with carry-in/carry-out.
- Drives every operand combination (a, b, cin) into the adder under test and samples the sum and carry-out after a fixed settle window.
- Compares against an internal reference sum and counts tests and mismatches, capturing the first failing vector.
- Sits beside rca-style adder instances on the lab board so a run can be triggered from a button and the pass/fail result shown on LEDs.

Parameters:
- WIDTH, 4, adder operand width in bits.
- SETTLE, 2, cycles operands are held before sampling; legal range ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled in IDLE and DONE only.
- abort  input  1  cancel the current run; sampled in WAIT and CHECK only.
- dut_a  output  WIDTH  operand a to the adder.
- dut_b  output  WIDTH  operand b to the adder.
- dut_cin  output  1  carry-in to the adder.
- dut_sum  input  WIDTH  sum from the adder.
- dut_cout  input  1  carry-out from the adder.
- busy  output  1  run in progress.
- done  output  1  run completed; held until the next start.
- pass  output  1  done and errors==0.
- tests  output  2*WIDTH+2  vectors checked this run.
- errors  output  2*WIDTH+2  mismatching vectors this run.
- fail_a  output  WIDTH  a of the first failing vector.
- fail_b  output  WIDTH  b of the first failing vector.
- fail_cin  output  1  cin of the first failing vector.
- fail_sum  output  WIDTH+1  captured {dut_cout,dut_sum} of the first failure.

Behaviour:
- Reset and state machine
  - Synchronous reset, active high, on clk rising edge; one clock, no other clock domains.
  - Reset forces state=IDLE and every output and internal register to 0 (vec, settle count, counters, fail capture). dut_a/dut_b/dut_cin are therefore 0 after reset.
  - Reset mid-run has the same effect: the run is discarded and done=0.
  - States: IDLE, WAIT, CHECK, DONE. busy=1 exactly in WAIT and CHECK.
- Vector register
  - vec is 2*WIDTH+1 bits; dut_a=vec[WIDTH-1:0], dut_b=vec[2*WIDTH-1:WIDTH], dut_cin=vec[2*WIDTH].
  - These outputs are driven directly from registers, with no combinational path from inputs.
- IDLE
  - start=1 → clear vec, settle count, tests, errors, fail_* and done; go to WAIT.
- WAIT
  - Settle count increments each cycle; at count==SETTLE-1 go to CHECK. WAIT therefore lasts exactly SETTLE cycles per vector.
- CHECK (single cycle)
  - exp = a + b + cin computed at WIDTH+1 bits.
  - tests += 1.
  - If {dut_cout,dut_sum} != exp: errors += 1. If this is the first mismatch (errors was 0), capture fail_a/b/cin from vec and fail_sum from the DUT.
  - If vec is all ones → DONE. Otherwise vec += 1, settle count = 0 → WAIT.
- DONE
  - done=1, pass=(errors==0), busy=0. Counters and fail_* hold.
  - start=1 → same clear-and-restart as from IDLE; done drops the following cycle.
- abort
  - abort=1 in WAIT/CHECK → IDLE next cycle.
  - A CHECK-cycle abort takes precedence: no count update that cycle.
  - done stays 0; tests and errors hold their partial values.
- Timing and widths
  - Vector k (k = vec value) is applied from the cycle after start, plus k*(SETTLE+1).
  - Total run = 2^(2*WIDTH+1) * (SETTLE+1) cycles from start accepted to done=1. For defaults: 512*3 = 1536 cycles.
  - Counter widths hold the full count 2^(2*WIDTH+1) without wrap. The maximum of 512 fits in 10 bits.
- Boundary conditions
  - start while busy is ignored.
  - X/Z on dut_sum or dut_cout counts as a mismatch (case-inequality semantics in simulation).

Test Plan:
- Correct adder model attached, defaults, start pulse → done=1 exactly 1536 cycles later; tests=512, errors=0, pass=1, fail_*=0.
- Adder with sum[0] stuck at 0 → errors=256, pass=0; first fail: fail_a=1, fail_b=0, fail_cin=0, fail_sum=5'b00000.
- Adder with cout stuck at 0 → errors=256; first fail: fail_a=15, fail_b=1, fail_cin=0, fail_sum=0.
- Correct adder, abort asserted at cycle 300 after start → IDLE next cycle, busy=0, done=0, tests=100. A following start completes a clean run: tests=512, pass=1.
- rst asserted mid-run at cycle 700 → next cycle all outputs 0, state IDLE. start held high during a run → no restart, tests still 512 at done.
- SETTLE=1, WIDTH=2 build with correct adder → done after 32*2 = 64 cycles, tests=32. Issuing start from DONE reruns identically.

Source files
------------

// File: rtl/adder_selftest.sv
// Exhaustive self-test sequencer for a WIDTH-bit ripple-carry adder with carry-in/out.
// Walks every (a, b, cin) vector, settles, compares against a reference sum and logs failures.
module adder_selftest #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   tests,
    output logic [2*WIDTH+1:0]   errors,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic                 fail_cin,
    output logic [WIDTH:0]       fail_sum
);

    localparam int VW = 2*WIDTH + 1;
    localparam int CW = 2*WIDTH + 2;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   tests_q, tests_d;
    logic [CW-1:0]   errors_q, errors_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic            fail_cin_q, fail_cin_d;
    logic [WIDTH:0]  fail_sum_q, fail_sum_d;

    logic [WIDTH:0]  exp_sum;
    logic            mismatch;
    logic            start_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            tests_q    <= '0;
            errors_q   <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_cin_q <= 1'b0;
            fail_sum_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            tests_q    <= tests_d;
            errors_q   <= errors_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_cin_q <= fail_cin_d;
            fail_sum_q <= fail_sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WAIT;
            S_WAIT: begin
                if (abort)                    state_d = S_IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (abort)         state_d = S_IDLE;
                else if (&vec_q)   state_d = S_DONE;
                else               state_d = S_WAIT;
            end
            S_DONE:  if (start) state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // Case-inequality so X/Z from the adder under test is scored as a mismatch.
    always_comb begin
        exp_sum  = (WIDTH+1)'(vec_q[WIDTH-1:0]) + (WIDTH+1)'(vec_q[2*WIDTH-1:WIDTH])
                 + (WIDTH+1)'(vec_q[2*WIDTH]);
        mismatch = ({dut_cout, dut_sum} !== exp_sum);
        start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    always_comb begin
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        tests_d    = tests_q;
        errors_d   = errors_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_cin_d = fail_cin_q;
        fail_sum_d = fail_sum_q;
        if (start_ok) begin
            vec_d      = '0;
            cnt_d      = '0;
            tests_d    = '0;
            errors_d   = '0;
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_cin_d = 1'b0;
            fail_sum_d = '0;
        end else if (state_q == S_WAIT && !abort) begin
            cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
        end else if (state_q == S_CHECK && !abort) begin
            tests_d = tests_q + 1'b1;
            if (mismatch) begin
                errors_d = errors_q + 1'b1;
                if (errors_q == '0) begin
                    fail_a_d   = vec_q[WIDTH-1:0];
                    fail_b_d   = vec_q[2*WIDTH-1:WIDTH];
                    fail_cin_d = vec_q[2*WIDTH];
                    fail_sum_d = {dut_cout, dut_sum};
                end
            end
            if (!(&vec_q)) begin
                vec_d = vec_q + 1'b1;
                cnt_d = '0;
            end
        end
    end

    always_comb begin
        busy     = (state_q == S_WAIT) || (state_q == S_CHECK);
        done     = (state_q == S_DONE);
        pass     = (state_q == S_DONE) && (errors_q == '0);
        dut_a    = vec_q[WIDTH-1:0];
        dut_b    = vec_q[2*WIDTH-1:WIDTH];
        dut_cin  = vec_q[2*WIDTH];
        tests    = tests_q;
        errors   = errors_q;
        fail_a   = fail_a_q;
        fail_b   = fail_b_q;
        fail_cin = fail_cin_q;
        fail_sum = fail_sum_q;
    end

endmodule

// File: tb/tb_adder_selftest.sv
// Directed bench for adder_selftest: good and faulty adder models, abort, mid-run reset,
// held start, and a reduced WIDTH=2/SETTLE=1 build.
module tb_adder_selftest;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] dut_a, dut_b, dut_sum;
    logic       dut_cin, dut_cout;
    logic       busy, done, pass;
    logic [9:0] tests, errors;
    logic [3:0] fail_a, fail_b;
    logic       fail_cin;
    logic [4:0] fail_sum;
    int         mode = 0;

    logic       s_start = 1'b0;
    logic [1:0] s_a, s_b, s_sum;
    logic       s_cin, s_cout;
    logic       s_busy, s_done, s_pass;
    logic [5:0] s_tests, s_errors;
    logic [1:0] s_fail_a, s_fail_b;
    logic       s_fail_cin;
    logic [2:0] s_fail_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Adder under test: 0 = correct, 1 = sum[0] stuck at 0, 2 = cout stuck at 0.
    logic [4:0] full;
    always_comb begin
        full     = {1'b0, dut_a} + {1'b0, dut_b} + {4'b0, dut_cin};
        dut_sum  = full[3:0];
        dut_cout = full[4];
        if (mode == 1) dut_sum  = full[3:0] & 4'b1110;
        if (mode == 2) dut_cout = 1'b0;
    end

    always_comb {s_cout, s_sum} = {1'b0, s_a} + {1'b0, s_b} + {2'b0, s_cin};

    adder_selftest u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
        .dut_sum(dut_sum), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass), .tests(tests), .errors(errors),
        .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin), .fail_sum(fail_sum)
    );

    adder_selftest #(.WIDTH(2), .SETTLE(1)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(1'b0),
        .dut_a(s_a), .dut_b(s_b), .dut_cin(s_cin),
        .dut_sum(s_sum), .dut_cout(s_cout),
        .busy(s_busy), .done(s_done), .pass(s_pass), .tests(s_tests), .errors(s_errors),
        .fail_a(s_fail_a), .fail_b(s_fail_b), .fail_cin(s_fail_cin), .fail_sum(s_fail_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start (or hold it for hold_cyc edges), then count edges until done.
    // Aborts or resets at the given cycle when non-zero.
    task automatic run_main(input int hold_cyc, input int abort_at, input int rst_at,
                            output int cyc);
        start = 1'b1;
        tick();
        cyc = 0;
        if (hold_cyc == 0) start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        while (!done && cyc < 3000) begin
            if (abort_at != 0 && cyc == abort_at) abort = 1'b1;
            if (rst_at != 0 && cyc == rst_at) rst = 1'b1;
            tick();
            cyc++;
            if (cyc == hold_cyc) start = 1'b0;
            if (cyc == 45 && abort_at == 0 && rst_at == 0) begin
                chk("vec15_a", dut_a, 15);
                chk("vec15_b", dut_b, 0);
            end
            if (abort) begin
                abort = 1'b0;
                return;
            end
            if (rst) begin
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int cyc;

        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_a", dut_a, 0);
        chk("rst_tests", tests, 0);
        chk("rst_errors", errors, 0);
        rst = 1'b0;
        tick();

        mode = 0;
        run_main(0, 0, 0, cyc);
        chk("good_cycles", cyc, 1536);
        chk("good_tests", tests, 512);
        chk("good_errors", errors, 0);
        chk("good_pass", pass, 1);
        chk("good_busy", busy, 0);
        chk("good_fail_a", fail_a, 0);
        chk("good_fail_sum", fail_sum, 0);

        mode = 1;
        run_main(0, 0, 0, cyc);
        chk("s0_cycles", cyc, 1536);
        chk("s0_errors", errors, 256);
        chk("s0_pass", pass, 0);
        chk("s0_done", done, 1);
        chk("s0_fail_a", fail_a, 1);
        chk("s0_fail_b", fail_b, 0);
        chk("s0_fail_cin", fail_cin, 0);
        chk("s0_fail_sum", fail_sum, 0);

        mode = 2;
        run_main(0, 0, 0, cyc);
        chk("co_tests", tests, 512);
        chk("co_errors", errors, 256);
        chk("co_fail_a", fail_a, 15);
        chk("co_fail_b", fail_b, 1);
        chk("co_fail_cin", fail_cin, 0);
        chk("co_fail_sum", fail_sum, 0);

        mode = 0;
        run_main(0, 300, 0, cyc);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_tests", tests, 100);
        chk("abort_errors", errors, 0);
        tick();
        chk("abort_idle_tests", tests, 100);
        run_main(0, 0, 0, cyc);
        chk("after_abort_tests", tests, 512);
        chk("after_abort_pass", pass, 1);

        run_main(0, 0, 700, cyc);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_tests", tests, 0);
        chk("mrst_a", dut_a, 0);
        chk("mrst_b", dut_b, 0);
        chk("mrst_cin", dut_cin, 0);

        run_main(1000, 0, 0, cyc);
        chk("hold_cycles", cyc, 1536);
        chk("hold_tests", tests, 512);
        chk("hold_pass", pass, 1);

        for (int r = 0; r < 2; r++) begin
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            cyc = 0;
            chk("small_busy", s_busy, 1);
            while (!s_done && cyc < 500) begin
                tick();
                cyc++;
            end
            chk("small_cycles", cyc, 64);
            chk("small_tests", s_tests, 32);
            chk("small_errors", s_errors, 0);
            chk("small_pass", s_pass, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
